// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding,
// requester ids and the default burst bound.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CORE_OWN = 2'd1,
        NIC_OWN  = 2'd2
    } state_t;

    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_NIC  = 1'b1;

    localparam int MAX_BURST_DEF = 4;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to the
// requester that was not the last owner.
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_owner,
    output logic gnt0,
    output logic gnt1
);

    assign gnt0 = req0 && (!req1 || (last_owner == REQ_NIC));
    assign gnt1 = req1 && (!req0 || (last_owner == REQ_CORE));

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between CORE (0) and NIC (1) with
// round-robin plus bounded locked bursts. Macro DMEM_ARB_CORE_PRIO_EN gives CORE fixed priority.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BURST  = MAX_BURST_DEF
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  core_req,
    input  logic                  core_we,
    input  logic                  core_lock,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic                  core_gnt,
    output logic                  core_rvalid,

    input  logic                  nic_req,
    input  logic                  nic_we,
    input  logic                  nic_lock,
    input  logic [ADDR_WIDTH-1:0] nic_addr,
    input  logic [DATA_WIDTH-1:0] nic_wdata,
    output logic                  nic_gnt,
    output logic                  nic_rvalid,

    output logic [DATA_WIDTH-1:0] rdata,

    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,

    output logic                  busy,
    output logic [1:0]            state
);

    // Handshake: a requester holds req/we/addr/wdata stable until it sees gnt
    // in the same cycle; gnt means the access reached the memory that cycle.
    // A granted read returns exactly one cycle later as *_rvalid with rdata.

    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);
    localparam bit LOCK_OK = (MAX_BURST > 1);

    state_t          state_q;
    logic            last_owner;
    logic [CW-1:0]   burst_cnt;

    logic            tie_owner;
    logic            nic_lock_eff;
    logic            pick_core;
    logic            pick_nic;
    logic            gnt_id;
    logic            gnt_lock;

`ifdef DMEM_ARB_CORE_PRIO_EN
    // Pretending NIC was last owner makes every IDLE tie go to CORE.
    assign tie_owner    = REQ_NIC;
    assign nic_lock_eff = 1'b0;
`else
    assign tie_owner    = last_owner;
    assign nic_lock_eff = nic_lock;
`endif

    rr_pick2 u_pick (
        .req0       (core_req),
        .req1       (nic_req),
        .last_owner (tie_owner),
        .gnt0       (pick_core),
        .gnt1       (pick_nic)
    );

    // Grants are held off while reset is asserted so the memory sees no access.
    always_comb begin
        core_gnt = 1'b0;
        nic_gnt  = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    core_gnt = pick_core;
                    nic_gnt  = pick_nic;
                end
                CORE_OWN: core_gnt = core_req;
                NIC_OWN:  nic_gnt  = nic_req;
                default: begin
                    core_gnt = 1'b0;
                    nic_gnt  = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        mem_en    = core_gnt | nic_gnt;
        mem_we    = nic_gnt ? nic_we    : (core_gnt & core_we);
        mem_addr  = nic_gnt ? nic_addr  : core_addr;
        mem_wdata = nic_gnt ? nic_wdata : core_wdata;
        gnt_id    = nic_gnt ? REQ_NIC   : REQ_CORE;
        gnt_lock  = nic_gnt ? nic_lock_eff : core_lock;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_owner  <= REQ_NIC;
            burst_cnt   <= '0;
            core_rvalid <= 1'b0;
            nic_rvalid  <= 1'b0;
        end else begin
            core_rvalid <= core_gnt & ~core_we;
            nic_rvalid  <= nic_gnt & ~nic_we;

            case (state_q)
                IDLE: begin
                    if (mem_en) begin
                        last_owner <= gnt_id;
                        if (gnt_lock && LOCK_OK) begin
                            state_q   <= (gnt_id == REQ_NIC) ? NIC_OWN : CORE_OWN;
                            burst_cnt <= CW'(1);
                        end
                    end
                end
                CORE_OWN, NIC_OWN: begin
                    // In an owned state mem_en is high exactly when the owner requests.
                    if (mem_en && gnt_lock && (burst_cnt < BURST_LAST)) begin
                        burst_cnt <= burst_cnt + CW'(1);
                    end else begin
                        state_q   <= IDLE;
                        burst_cnt <= '0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    burst_cnt <= '0;
                end
            endcase
        end
    end

    assign rdata = (core_rvalid | nic_rvalid) ? mem_rdata : '0;
    assign busy  = (state_q != IDLE);
    assign state = state_q;

    a_gnt_excl: assert property (@(posedge clk) !(core_gnt && nic_gnt));
    a_rvalid_excl: assert property (@(posedge clk) !(core_rvalid && nic_rvalid));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a driver issues cycles with hand-computed
// grant/busy expectations and queues expected read returns; a monitor checks them.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_CORE_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req, core_we, core_lock;
    logic [31:0] core_addr;
    logic [63:0] core_wdata;
    logic        core_gnt, core_rvalid;
    logic        nic_req, nic_we, nic_lock;
    logic [31:0] nic_addr;
    logic [63:0] nic_wdata;
    logic        nic_gnt, nic_rvalid;
    logic [63:0] rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata = 64'd0;
    logic        busy;
    logic [1:0]  state;

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    // {cycle stamp[15:0], id, data[63:0]}
    logic [80:0] exp_q[$];

    logic [63:0] mem [0:255];

    localparam logic [63:0] D1 = 64'hA000_0000_0000_0001;
    localparam logic [63:0] D2 = 64'hA000_0000_0000_0002;
    localparam logic [63:0] D3 = 64'hA000_0000_0000_0003;
    localparam logic [63:0] DW = 64'hDEAD_BEEF_0000_CAFE;

    dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_lock(core_lock),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid),
        .nic_req(nic_req), .nic_we(nic_we), .nic_lock(nic_lock),
        .nic_addr(nic_addr), .nic_wdata(nic_wdata),
        .nic_gnt(nic_gnt), .nic_rvalid(nic_rvalid),
        .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .state(state)
    );

    // Clock / reset-independent infrastructure
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 64'hA000_0000_0000_0000 | 64'(i);
    end

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[10:3]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[10:3]];
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Checks the current cycle's grants/busy, queues an expected read, advances a cycle.
    task automatic step(input string name, input logic e_cg, input logic e_ng,
                        input logic e_busy, input logic e_rd, input logic [63:0] e_data);
        #1;
        chk({name, "_gnt_busy"}, {125'd0, core_gnt, nic_gnt, busy}, {125'd0, e_cg, e_ng, e_busy});
        if (e_rd) exp_q.push_back({16'(cyc + 1), e_ng, e_data});
        @(negedge clk);
    endtask

    // Scoreboard monitor
    initial begin
        logic [80:0] e;
        forever begin
            @(negedge clk);
            if (core_rvalid || nic_rvalid) begin
                chk("rvalid_excl", {127'd0, core_rvalid && nic_rvalid}, 128'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL rvalid_unexpected: core_rvalid=%0b nic_rvalid=%0b rdata=%0h, none expected (cycle %0d)",
                             core_rvalid, nic_rvalid, rdata, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("rvalid_cycle", 128'(cyc), {112'd0, e[80:65]});
                    chk("rvalid_id", {127'd0, nic_rvalid}, {127'd0, e[64]});
                    chk("rdata", {64'd0, rdata}, {64'd0, e[63:0]});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got no end expected end");
        $fatal(1, "timeout");
    end

    // Driver
    initial begin
        rst = 1'b1;
        core_req = 1'b1; core_we = 1'b0; core_lock = 1'b0; core_addr = 32'h08; core_wdata = '0;
        nic_req  = 1'b1; nic_we  = 1'b0; nic_lock  = 1'b0; nic_addr  = 32'h10; nic_wdata  = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_ctl", {122'd0, core_gnt, nic_gnt, mem_en, busy, core_rvalid, nic_rvalid}, 128'd0);
        chk("reset_rdata", {64'd0, rdata}, 128'd0);
        chk("reset_state", {126'd0, state}, 128'd0);
        @(negedge clk);
        rst = 1'b0;

`ifndef DMEM_ARB_CORE_PRIO_EN
        // Round-robin alternation, CORE wins the first tie
        step("rr1", 1, 0, 0, 1, D1);
        step("rr2", 0, 1, 0, 1, D2);
        step("rr3", 1, 0, 0, 1, D1);
        step("rr4", 0, 1, 0, 1, D2);

        // Locked CORE burst capped at 4, then NIC
        core_lock = 1'b1; core_addr = 32'h18;
        step("bu1", 1, 0, 0, 1, D3);
        step("bu2", 1, 0, 1, 1, D3);
        step("bu3", 1, 0, 1, 1, D3);
        step("bu4", 1, 0, 1, 1, D3);
        step("bu5", 0, 1, 0, 1, D2);
`else
        // CORE priority: ties always to CORE
        step("pr1", 1, 0, 0, 1, D1);
        step("pr2", 1, 0, 0, 1, D1);
        step("pr3", 1, 0, 0, 1, D1);
        step("pr4", 1, 0, 0, 1, D1);
        // NIC lock ignored: single-cycle grants, never busy
        core_req = 1'b0; nic_lock = 1'b1;
        step("pn1", 0, 1, 0, 1, D2);
        step("pn2", 0, 1, 0, 1, D2);
        step("pn3", 0, 1, 0, 1, D2);
`endif
        core_req = 1'b0; nic_req = 1'b0; core_lock = 1'b0; nic_lock = 1'b0;
        step("idle1", 0, 0, 0, 0, 64'd0);

        // NIC write then CORE read-back
        nic_req = 1'b1; nic_we = 1'b1; nic_addr = 32'h100; nic_wdata = DW;
        #1;
        chk("mem_wr", {30'd0, mem_en, mem_we, mem_addr, mem_wdata}, {30'd0, 1'b1, 1'b1, 32'h100, DW});
        step("wr", 0, 1, 0, 0, 64'd0);
        nic_req = 1'b0; nic_we = 1'b0;
        core_req = 1'b1; core_addr = 32'h100;
        #1;
        chk("mem_rd", {94'd0, mem_en, mem_we, mem_addr}, {94'd0, 1'b1, 1'b0, 32'h100});
        step("rd100", 1, 0, 0, 1, DW);
        core_req = 1'b0;
        step("idle2", 0, 0, 0, 0, 64'd0);

        // CORE lock, then req dropped for a cycle while NIC waits
        core_req = 1'b1; core_lock = 1'b1; core_addr = 32'h08;
        step("lk1", 1, 0, 0, 1, D1);
        nic_req = 1'b1; nic_addr = 32'h10;
        #1;
        chk("lk2_state", {126'd0, state}, 128'd1);
        step("lk2", 1, 0, 1, 1, D1);
        core_req = 1'b0;
        step("drop", 0, 0, 1, 0, 64'd0);
        #1;
        chk("drop_idle", {126'd0, state}, 128'd0);
        step("lk_nic", 0, 1, 0, 1, D2);
        core_lock = 1'b0; nic_req = 1'b0;
        step("idle3", 0, 0, 0, 0, 64'd0);

        // Reset in the middle of a NIC burst
        nic_req = 1'b1; nic_lock = 1'b1; nic_addr = 32'h10;
        step("nb1", 0, 1, 0, 1, D2);
        #1;
        chk("nb2_state", {126'd0, state}, PRIO ? 128'd0 : 128'd2);
        step("nb2", 0, 1, !PRIO, 1, D2);
        rst = 1'b1;
        step("nb_rst", 0, 0, !PRIO, 0, 64'd0);
        rst = 1'b0;
        core_req = 1'b1; core_addr = 32'h08; nic_lock = 1'b0;
        #1;
        chk("rst_nic_rvalid", {127'd0, nic_rvalid}, 128'd0);
        chk("rst_state", {126'd0, state}, 128'd0);
        step("post_tie", 1, 0, 0, 1, D1);
        core_req = 1'b0; nic_req = 1'b0;
        step("idle4", 0, 0, 0, 0, 64'd0);

        repeat (3) @(negedge clk);
        #1;
        chk("exp_q_empty", 128'(exp_q.size()), 128'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
